pyc_byte_mem_dma: RTL

Byte-granular copy/fill engine that acts as the initiator for a byte-addressed memory with a combinational little-endian read window and a byte-strobed posedge write port. It accepts one command (copy src->dst of len bytes, or fill dst with a byte value), moves up to STRB_WIDTH bytes per cycle, and is overlap-safe (memmove semantics). It sits between a control agent (core/TB sequencer) and the memory.

---
 rtl/pyc_byte_mem_dma.sv | 81 ++++++++
 1 files changed

// File: rtl/pyc_byte_mem_dma.sv
// pyc_byte_mem_dma: overlap-safe byte copy/fill engine, up to STRB_WIDTH bytes per cycle
// Ports: clk/rst (async active-high); cmd_* command handshake (accepted only in IDLE);
//        busy/done status; mem_raddr/mem_rdata combinational read window;
//        mem_wvalid/mem_waddr/mem_wdata/mem_wstrb byte-strobed write port.
module pyc_byte_mem_dma #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH = 32,
    localparam int STRB_WIDTH = (DATA_WIDTH + 7) / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_src,
    input  logic [ADDR_WIDTH-1:0] cmd_dst,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  cmd_fill,
    input  logic [7:0]            cmd_fill_byte,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_wvalid,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [STRB_WIDTH-1:0] mem_wstrb
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [ADDR_WIDTH-1:0] src, dst;
    logic [LEN_WIDTH-1:0] len, rem, b, off;
    logic fill, bwd, run, cmd_bwd;
    logic [7:0] fb;
    always_comb begin
        run = state == RUN;
        cmd_ready = state == IDLE;
        busy = state != IDLE;
        done = state == DONE;
        b = rem < LEN_WIDTH'(STRB_WIDTH) ? rem : LEN_WIDTH'(STRB_WIDTH);
        // backward walks chunks from the top so an overlapping dst never clobbers unread src bytes
        off = bwd ? rem - b : len - rem;
        cmd_bwd = !cmd_fill && cmd_dst > cmd_src &&
                  {1'b0, cmd_dst} < {1'b0, cmd_src} + (ADDR_WIDTH+1)'(cmd_len);
        mem_wvalid = run;
        mem_raddr = run ? src + ADDR_WIDTH'(off) : '0;
        mem_waddr = run ? dst + ADDR_WIDTH'(off) : '0;
        mem_wstrb = run ? STRB_WIDTH'({STRB_WIDTH{1'b1}} >> (LEN_WIDTH'(STRB_WIDTH) - b)) : '0;
        mem_wdata = run ? (fill ? DATA_WIDTH'({STRB_WIDTH{fb}}) : mem_rdata) : '0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            src <= '0;
            dst <= '0;
            len <= '0;
            rem <= '0;
            fill <= 1'b0;
            fb <= '0;
            bwd <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    src <= cmd_src;
                    dst <= cmd_dst;
                    len <= cmd_len;
                    rem <= cmd_len;
                    fill <= cmd_fill;
                    fb <= cmd_fill_byte;
                    bwd <= cmd_bwd;
                    state <= cmd_len == '0 ? DONE : RUN;
                end
                RUN: begin
                    rem <= rem - b;
                    state <= rem == b ? DONE : RUN;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
